// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART core with TX/RX FIFOs, 16x oversampling, sticky errors; parity via UART_FIFO_CORE_PARITY_EN
module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 27,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DIN,
  input  logic                 WRN,
  input  logic                 RDN,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 DATA_READY,
  output logic                 TX_BUFFER_EMPTY,
  output logic                 TX_FULL,
  input  logic                 RXD,
  output logic                 SDO,
  input  logic                 ERR_CLR,
`ifdef UART_FIFO_CORE_PARITY_EN
  input  logic                 PARITY_ODD,
`endif
  output logic                 FRAMING_ERR,
  output logic                 OVERRUN_ERR,
  output logic                 PARITY_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [4:0]    STOP_LAST = 5'(STOP_BITS * 16 - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // ---------------- oversample tick ----------------
  logic [BW-1:0] baud_cnt;
  logic          tick;
  assign tick = (baud_cnt == BW'(BAUD_DIV - 1));

  // Free-running divider producing one tick per BAUD_DIV clocks
  always_ff @(posedge CLK) begin
    if (RST || tick) baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + 1'b1;
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wptr, tx_rptr;
  logic [CW-1:0]        tx_count, tx_count_n;
  logic                 tx_push, tx_pop, tx_not_empty;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_push      = !WRN && !TX_FULL;
  assign tx_not_empty = (tx_count != '0);
  assign tx_head      = tx_mem[tx_rptr];
  assign tx_count_n   = tx_count + CW'(tx_push) - CW'(tx_pop);

  // TX storage write port; contents need no reset since count gates use
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wptr] <= DIN;
  end

  // TX pointers, occupancy and the registered full flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      TX_FULL  <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      tx_count <= tx_count_n;
      TX_FULL  <= (tx_count_n == DEPTH_C);
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_state_n;
  logic [4:0]           tx_tcnt, tx_tcnt_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 sdo_n;
`ifdef UART_FIFO_CORE_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  assign TX_BUFFER_EMPTY = !tx_not_empty && (tx_state == ST_IDLE);

  // TX state register; reset forces the line idle-high immediately
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= ST_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      SDO      <= 1'b1;
`ifdef UART_FIFO_CORE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      SDO      <= sdo_n;
`ifdef UART_FIFO_CORE_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state: each state spans 16 ticks; a pop at stop end chains frames with no gap
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    sdo_n      = SDO;
    tx_pop     = 1'b0;
`ifdef UART_FIFO_CORE_PARITY_EN
    tx_par_n   = tx_par;
`endif
    if (tick) begin
      case (tx_state)
        ST_IDLE: tx_pop = tx_not_empty;
        ST_START: begin
          if (tx_tcnt == 5'd15) begin
            tx_state_n = ST_DATA;
            tx_tcnt_n  = '0;
            tx_bit_n   = '0;
            sdo_n      = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
          end else tx_tcnt_n = tx_tcnt + 5'd1;
        end
        ST_DATA: begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt_n = '0;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_FIFO_CORE_PARITY_EN
              tx_state_n = ST_PARITY;
              sdo_n      = tx_par;
`else
              tx_state_n = ST_STOP;
              sdo_n      = 1'b1;
`endif
            end else begin
              tx_bit_n   = tx_bit + 3'd1;
              sdo_n      = tx_shift[0];
              tx_shift_n = tx_shift >> 1;
            end
          end else tx_tcnt_n = tx_tcnt + 5'd1;
        end
`ifdef UART_FIFO_CORE_PARITY_EN
        ST_PARITY: begin
          if (tx_tcnt == 5'd15) begin
            tx_state_n = ST_STOP;
            tx_tcnt_n  = '0;
            sdo_n      = 1'b1;
          end else tx_tcnt_n = tx_tcnt + 5'd1;
        end
`endif
        ST_STOP: begin
          if (tx_tcnt == STOP_LAST) begin
            tx_state_n = ST_IDLE;
            tx_tcnt_n  = '0;
            tx_pop     = tx_not_empty;
          end else tx_tcnt_n = tx_tcnt + 5'd1;
        end
        default: tx_state_n = ST_IDLE;
      endcase
      if (tx_pop) begin
        tx_state_n = ST_START;
        tx_tcnt_n  = '0;
        tx_shift_n = tx_head;
        sdo_n      = 1'b0;
`ifdef UART_FIFO_CORE_PARITY_EN
        tx_par_n   = (^tx_head) ^ PARITY_ODD;
`endif
      end
    end
  end

  // ---------------- RX conditioning ----------------
  logic rx_meta, rx_sync;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wptr, rx_rptr;
  logic [CW-1:0]        rx_count;
  logic                 rx_push, rx_pop, rx_full;

  assign DATA_READY = (rx_count != '0);
  assign rx_full    = (rx_count == DEPTH_C);
  assign rx_pop     = !RDN && DATA_READY;
  assign DOUT       = DATA_READY ? rx_mem[rx_rptr] : '0;

  // ---------------- RX FSM ----------------
  state_t               rx_state, rx_state_n;
  logic [3:0]           rx_tcnt, rx_tcnt_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 fe_set, oe_set;
`ifdef UART_FIFO_CORE_PARITY_EN
  logic                 rx_par_bad, rx_par_bad_n, pe_set;
`endif

  // RX storage write port for completed characters
  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_shift;
  end

  // RX pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // RX state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state   <= ST_IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
`ifdef UART_FIFO_CORE_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_state   <= rx_state_n;
      rx_tcnt    <= rx_tcnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
`ifdef UART_FIFO_CORE_PARITY_EN
      rx_par_bad <= rx_par_bad_n;
`endif
    end
  end

  // RX next state: verify start at tick 8, then sample every 16 ticks at mid-bit
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    oe_set     = 1'b0;
`ifdef UART_FIFO_CORE_PARITY_EN
    rx_par_bad_n = rx_par_bad;
    pe_set       = 1'b0;
`endif
    if (tick) begin
      case (rx_state)
        ST_IDLE: begin
          if (!rx_sync) begin
            rx_state_n = ST_START;
            rx_tcnt_n  = '0;
          end
        end
        ST_START: begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n  = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
          end else rx_tcnt_n = rx_tcnt + 4'd1;
        end
        ST_DATA: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n  = '0;
            rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_FIFO_CORE_PARITY_EN
              rx_state_n = ST_PARITY;
`else
              rx_state_n = ST_STOP;
`endif
            end else rx_bit_n = rx_bit + 3'd1;
          end else rx_tcnt_n = rx_tcnt + 4'd1;
        end
`ifdef UART_FIFO_CORE_PARITY_EN
        ST_PARITY: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n    = '0;
            rx_state_n   = ST_STOP;
            rx_par_bad_n = (rx_sync != ((^rx_shift) ^ PARITY_ODD));
          end else rx_tcnt_n = rx_tcnt + 4'd1;
        end
`endif
        ST_STOP: begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_n  = '0;
            rx_state_n = ST_IDLE;
            fe_set     = !rx_sync;
            oe_set     = rx_full;
            rx_push    = !rx_full;
`ifdef UART_FIFO_CORE_PARITY_EN
            pe_set     = rx_par_bad;
`endif
          end else rx_tcnt_n = rx_tcnt + 4'd1;
        end
        default: rx_state_n = ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      FRAMING_ERR <= 1'b0;
      OVERRUN_ERR <= 1'b0;
    end else begin
      FRAMING_ERR <= fe_set | (FRAMING_ERR & ~ERR_CLR);
      OVERRUN_ERR <= oe_set | (OVERRUN_ERR & ~ERR_CLR);
    end
  end

`ifdef UART_FIFO_CORE_PARITY_EN
  // Sticky parity flag
  always_ff @(posedge CLK) begin
    if (RST) PARITY_ERR <= 1'b0;
    else     PARITY_ERR <= pe_set | (PARITY_ERR & ~ERR_CLR);
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - scoreboard bench for uart_fifo_core
module tb_uart_fifo_core;
  localparam int DB       = 8;
  localparam int DEPTH    = 16;
  localparam int BD       = 4;
  localparam int BIT_CLKS = 16 * BD;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DB-1:0] DIN = '0;
  logic          WRN = 1'b1;
  logic          RDN = 1'b1;
  logic [DB-1:0] DOUT;
  logic          DATA_READY, TX_BUFFER_EMPTY, TX_FULL;
  logic          RXD, SDO;
  logic          ERR_CLR = 1'b0;
  logic          FRAMING_ERR, OVERRUN_ERR, PARITY_ERR;
  logic          loop_en = 1'b0;
  logic          rxd_drv = 1'b1;
`ifdef UART_FIFO_CORE_PARITY_EN
  logic          parity_odd = 1'b0;
`endif

  assign RXD = loop_en ? SDO : rxd_drv;

  int checks   = 0;
  int failures = 0;

  logic [DB-1:0] rx_exp[$];
  logic          exp_fe = 1'b0;
  logic          exp_oe = 1'b0;

  uart_fifo_core #(
    .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BD), .STOP_BITS(1)
  ) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .WRN(WRN), .RDN(RDN), .DOUT(DOUT),
    .DATA_READY(DATA_READY), .TX_BUFFER_EMPTY(TX_BUFFER_EMPTY), .TX_FULL(TX_FULL),
    .RXD(RXD), .SDO(SDO), .ERR_CLR(ERR_CLR),
`ifdef UART_FIFO_CORE_PARITY_EN
    .PARITY_ODD(parity_odd),
`endif
    .FRAMING_ERR(FRAMING_ERR), .OVERRUN_ERR(OVERRUN_ERR), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic write_char(input logic [DB-1:0] b);
    DIN = b;
    WRN = 1'b0;
    clk_n(1);
    WRN = 1'b1;
  endtask

  task automatic read_char();
    RDN = 1'b0;
    clk_n(1);
    RDN = 1'b1;
  endtask

  // Reference model of the receive side: bounded queue plus sticky flags
  task automatic model_rx(input logic [DB-1:0] b, input logic stop_ok);
    if (!stop_ok) exp_fe = 1'b1;
    if (rx_exp.size() == DEPTH) exp_oe = 1'b1;
    else rx_exp.push_back(b);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_lvl);
    model_rx(b, stop_lvl);
    rxd_drv = 1'b0;
    clk_n(BIT_CLKS);
    for (int i = 0; i < DB; i++) begin
      rxd_drv = b[i];
      clk_n(BIT_CLKS);
    end
    rxd_drv = stop_lvl;
    clk_n(BIT_CLKS);
    rxd_drv = 1'b1;
    clk_n(16);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_fe"}, FRAMING_ERR, exp_fe);
    chk({tag, "_oe"}, OVERRUN_ERR, exp_oe);
    chk({tag, "_pe"}, PARITY_ERR, 0);
  endtask

  task automatic err_clear();
    ERR_CLR = 1'b1;
    clk_n(1);
    ERR_CLR = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = rx_exp.size();
    chk({tag, "_ready"}, DATA_READY, (n != 0));
    repeat (n) read_char();
    chk({tag, "_consumed"}, rx_exp.size(), 0);
    chk({tag, "_empty_after"}, DATA_READY, 0);
  endtask

  task automatic wait_tx_idle(input int budget);
    int k;
    k = 0;
    while (!TX_BUFFER_EMPTY && k < budget) begin
      clk_n(1);
      k++;
    end
    chk("tx_idle_reached", TX_BUFFER_EMPTY, 1);
  endtask

  // Monitor: every accepted read is compared against the scoreboard head
  always @(negedge CLK) begin
    if (!RST && !RDN && DATA_READY) begin
      if (rx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", DOUT);
      end else begin
        chk("rx_data", DOUT, rx_exp.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] b;
    logic          lvl;
    int            bad, k, n;

    // Reset state
    clk_n(3);
    chk("rst_sdo", SDO, 1);
    chk("rst_dout", DOUT, 0);
    chk("rst_ready", DATA_READY, 0);
    chk("rst_tbe", TX_BUFFER_EMPTY, 1);
    chk("rst_full", TX_FULL, 0);
    check_flags("rst");
    RST = 1'b0;
    clk_n(2);

    // TX waveform of 0xA5: start, LSB-first data, stop, each 64 clocks
    b = 8'hA5;
    write_char(b);
    k = 0;
    while (SDO && k < 10) begin
      clk_n(1);
      k++;
    end
    chk("tx_start_found", SDO, 0);
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      lvl = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : b[bit_i-1];
      bad = 0;
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (SDO !== lvl) bad++;
        if (bit_i == 9 && c == BIT_CLKS - 1) chk("tbe_last_stop_cycle", TX_BUFFER_EMPTY, 0);
        clk_n(1);
      end
      chk($sformatf("tx_bit%0d_bad_cycles", bit_i), bad, 0);
    end
    chk("tbe_after_stop", TX_BUFFER_EMPTY, 1);

    // Loopback of fixed characters
    loop_en = 1'b1;
    clk_n(2);
    foreach (b[i]) ;
    write_char(8'h00); model_rx(8'h00, 1'b1);
    write_char(8'hFF); model_rx(8'hFF, 1'b1);
    write_char(8'h3C); model_rx(8'h3C, 1'b1);
    k = 0;
    while (!DATA_READY && k < 800) begin
      clk_n(1);
      k++;
    end
    chk("loop_first_ready", DATA_READY, 1);
    wait_tx_idle(3 * 700);
    clk_n(20);
    check_flags("loop_fixed");
    drain("loop_fixed");

    // Randomized loopback burst
    n = $urandom_range(4, DEPTH);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      write_char(b);
      model_rx(b, 1'b1);
    end
    wait_tx_idle(n * 700);
    clk_n(20);
    check_flags("loop_burst");
    drain("loop_burst");

    // Read with nothing available is ignored
    read_char();
    chk("empty_read_dout", DOUT, 0);
    chk("empty_read_ready", DATA_READY, 0);

    // Overrun: 17 random characters, no reads
    loop_en = 1'b0;
    clk_n(5);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) chk("oe_before_17th", OVERRUN_ERR, 0);
      b = 8'($urandom);
      send_frame(b, 1'b1);
    end
    check_flags("overrun");
    drain("overrun");
    chk("oe_sticky_after_reads", OVERRUN_ERR, 1);
    err_clear();
    check_flags("oe_cleared");

    // Framing error: stop bit low, character still stored
    send_frame(8'h55, 1'b0);
    check_flags("framing");
    drain("framing");
    err_clear();
    check_flags("fe_cleared");

    // Short low glitch is a false start
    rxd_drv = 1'b0;
    clk_n(20);
    rxd_drv = 1'b1;
    clk_n(700);
    chk("glitch_no_data", DATA_READY, 0);
    check_flags("glitch");

    // TX_FULL boundary, then reset in the middle of a frame
    b = 8'($urandom);
    send_frame(b, 1'b1);
    chk("pre_reset_ready", DATA_READY, 1);
    write_char(8'h00);
    for (int i = 0; i < DEPTH - 1; i++) write_char(8'($urandom));
    chk("tx_full_after_16_writes", TX_FULL, 0);
    write_char(8'($urandom));
    chk("tx_full_after_17_writes", TX_FULL, 1);
    write_char(8'($urandom));
    clk_n(100);
    chk("sdo_low_before_reset", SDO, 0);
    RST = 1'b1;
    clk_n(1);
    chk("midrst_sdo", SDO, 1);
    chk("midrst_tbe", TX_BUFFER_EMPTY, 1);
    chk("midrst_full", TX_FULL, 0);
    chk("midrst_ready", DATA_READY, 0);
    chk("midrst_dout", DOUT, 0);
    RST = 1'b0;
    rx_exp.delete();
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    loop_en = 1'b1;
    clk_n(2);
    b = 8'($urandom);
    write_char(b);
    model_rx(b, 1'b1);
    wait_tx_idle(800);
    clk_n(20);
    check_flags("post_reset");
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
